// File: rtl/unsigned_restoring_div_16by8_seq.sv
// Sequential unsigned restoring divider: DW-bit dividend z by VW-bit divisor y.
// One quotient bit is retired per cycle, with valid/ready handshakes on both
// sides and a single operation in flight.
// Optional feature macro: DIV_EXACT_FLAG_EN adds the 'exact' output, which is
// high while a non-divide-by-zero result with zero remainder is held.
module unsigned_restoring_div_16by8_seq #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] z,
  input  logic [VW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
`ifdef DIV_EXACT_FLAG_EN
  output logic          exact,
`endif
  output logic          div_zero
);

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_RUN   = 2'd1;
  localparam logic [1:0]    ST_DONE  = 2'd2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [1:0]    state_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [VW-1:0] y_r;
  logic [VW:0]   rem_r;
  logic [DW-1:0] quo_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] q_r;
  logic [VW-1:0] r_r;
  logic          dz_r;
`ifdef DIV_EXACT_FLAG_EN
  logic          exact_r;
`endif

  // Partial remainder is extended by one bit so the trial subtraction's
  // sign bit is exact: after the shift the value is always below 2*y.
  logic [VW+1:0] shifted_s;
  logic [VW+1:0] diff_s;
  logic [VW:0]   rem_next_s;
  logic [DW-1:0] quo_next_s;

  // One restoring iteration: shift, trial-subtract, keep or restore.
  always_comb begin
    shifted_s = {rem_r, quo_r[DW-1]};
    diff_s    = shifted_s - {2'b00, y_r};
    if (diff_s[VW+1] == 1'b0) begin
      rem_next_s = diff_s[VW:0];
      quo_next_s = {quo_r[DW-2:0], 1'b1};
    end else begin
      rem_next_s = shifted_s[VW:0];
      quo_next_s = {quo_r[DW-2:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  // A y==0 operation takes one pass through RUN with a zero count, carrying
  // the all-ones result in the working registers, so it completes one cycle
  // after the accept edge just as a normal operation completes DW+1 later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= {VW{1'b0}};
      rem_r       <= {(VW+1){1'b0}};
      quo_r       <= {DW{1'b0}};
      cnt_r       <= CNT_ZERO;
      q_r         <= {DW{1'b0}};
      r_r         <= {VW{1'b0}};
      dz_r        <= 1'b0;
`ifdef DIV_EXACT_FLAG_EN
      exact_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r    <= ST_RUN;
            in_ready_r <= 1'b0;
            y_r        <= y;
            if (y == {VW{1'b0}}) begin
              rem_r <= {1'b0, {VW{1'b1}}};
              quo_r <= {DW{1'b1}};
              cnt_r <= CNT_ZERO;
              dz_r  <= 1'b1;
            end else begin
              rem_r <= {(VW+1){1'b0}};
              quo_r <= z;
              cnt_r <= CNT_LOAD;
              dz_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_ZERO) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            q_r         <= quo_r;
            r_r         <= rem_r[VW-1:0];
`ifdef DIV_EXACT_FLAG_EN
            exact_r     <= (rem_r == {(VW+1){1'b0}}) && !dz_r;
`endif
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
`ifdef DIV_EXACT_FLAG_EN
            exact_r     <= 1'b0;
`endif
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign r         = r_r;
  assign div_zero  = dz_r;
`ifdef DIV_EXACT_FLAG_EN
  assign exact     = exact_r;
`endif

endmodule
